fetch_sequencer: RTL and testbench

- Control unit that runs the instruction-fetch cycle around the program counter, the program memory and the instruction register.
- Per instruction, in order:
  - drives the PC onto the address bus (pc_out_en) and requests a memory read;
  - waits for memory with a timeout, then captures the instruction word;
  - pulses the PC increment (pc_count);
  - hands the instruction to the execute stage and waits for it to finish.
- Sits between PC, program memory and the execute unit in the microcontroller top level.

---
 rtl/fetch_sequencer.sv | 137 +++++++++++++
 tb/tb_fetch_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: drives PC onto the address bus, waits for
// program memory (with timeout), latches the IR, bumps the PC, then runs execute.
module fetch_sequencer #(
    parameter int INSTR_W  = 16,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               halt_req,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] mem_data,
    input  logic               exec_done,
    output logic               pc_out_en,
    output logic               pc_count,
    output logic               mem_rd,
    output logic               ir_load,
    output logic [INSTR_W-1:0] ir,
    output logic               exec_start,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic [CNT_W-1:0]   fetch_count,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WAIT  = 3'd2,
        S_LOAD  = 3'd3,
        S_INCR  = 3'd4,
        S_EXEC  = 3'd5,
        S_HALT  = 3'd6,
        S_FAULT = 3'd7
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_wait_cnt;
    logic [INSTR_W-1:0] r_ir;
    logic [CNT_W-1:0]   r_fetch_count;
    logic               r_exec_first;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= 8'd0;
            r_ir          <= '0;
            r_fetch_count <= '0;
            r_exec_first  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Only INCR leads into EXEC, so this marks exactly the first EXEC cycle.
            r_exec_first <= (r_state == S_INCR);
            case (r_state)
                S_ADDR: r_wait_cnt <= 8'd0;
                S_WAIT: begin
                    if (mem_ready) begin
                        r_ir <= mem_data;
                    end else if (r_wait_cnt != WAIT_LAST) begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_INCR: r_fetch_count <= r_fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        pc_out_en    = 1'b0;
        pc_count     = 1'b0;
        mem_rd       = 1'b0;
        ir_load      = 1'b0;
        exec_start   = 1'b0;
        busy         = 1'b1;
        halted       = 1'b0;
        fault        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (run) w_state_next = S_ADDR;
            end
            S_ADDR: begin
                pc_out_en    = 1'b1;
                mem_rd       = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                pc_out_en = 1'b1;
                mem_rd    = 1'b1;
                // Ready in the last permitted cycle beats the timeout.
                if (mem_ready) begin
                    w_state_next = S_LOAD;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_state_next = S_FAULT;
                end
            end
            S_LOAD: begin
                ir_load      = 1'b1;
                w_state_next = S_INCR;
            end
            S_INCR: begin
                pc_count     = 1'b1;
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                exec_start = r_exec_first;
                if (exec_done) begin
                    if (halt_req)  w_state_next = S_HALT;
                    else if (run)  w_state_next = S_ADDR;
                    else           w_state_next = S_IDLE;
                end
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
                if (!run) w_state_next = S_IDLE;
            end
            S_FAULT: begin
                busy  = 1'b0;
                fault = 1'b1;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign ir          = r_ir;
    assign fetch_count = r_fetch_count;
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected IR words are queued when memory
// data is driven and popped when the DUT strobes ir_load.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, halt_req, mem_ready, exec_done;
    logic [15:0] mem_data;

    logic        pc_out_en, pc_count, mem_rd, ir_load, exec_start, busy, halted, fault;
    logic [15:0] ir, fetch_count;
    logic [2:0]  state_dbg;

    logic        d4_pc_out_en, d4_pc_count, d4_mem_rd, d4_ir_load, d4_exec_start;
    logic        d4_busy, d4_halted, d4_fault;
    logic [15:0] d4_ir;
    logic [3:0]  d4_fetch_count;
    logic [2:0]  d4_state_dbg;

    logic [7:0]  w_outs;
    assign w_outs = {pc_out_en, pc_count, mem_rd, ir_load, exec_start, busy, halted, fault};

    always #5 clk = ~clk;

    fetch_sequencer #(.INSTR_W(16), .WAIT_MAX(15), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .run(run), .halt_req(halt_req),
        .mem_ready(mem_ready), .mem_data(mem_data), .exec_done(exec_done),
        .pc_out_en(pc_out_en), .pc_count(pc_count), .mem_rd(mem_rd),
        .ir_load(ir_load), .ir(ir), .exec_start(exec_start), .busy(busy),
        .halted(halted), .fault(fault), .fetch_count(fetch_count),
        .state_dbg(state_dbg)
    );

    fetch_sequencer #(.INSTR_W(16), .WAIT_MAX(15), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .run(run), .halt_req(halt_req),
        .mem_ready(mem_ready), .mem_data(mem_data), .exec_done(exec_done),
        .pc_out_en(d4_pc_out_en), .pc_count(d4_pc_count), .mem_rd(d4_mem_rd),
        .ir_load(d4_ir_load), .ir(d4_ir), .exec_start(d4_exec_start), .busy(d4_busy),
        .halted(d4_halted), .fault(d4_fault), .fetch_count(d4_fetch_count),
        .state_dbg(d4_state_dbg)
    );

    int          checks = 0;
    int          failures = 0;
    int          pc_pulses = 0;
    int          exp_pulses = 0;
    int          en_cycles;
    int          wait_seen;
    logic [15:0] exp_q[$];
    logic [15:0] exp_ir;
    logic [2:0]  basic_seq[6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1ns after the edge, and service the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ir_load) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_ir = exp_q.pop_front();
                check("ir_on_load", {16'h0, ir}, {16'h0, exp_ir});
                $display("fetch: ir=%04h expected=%04h fetch_count=%0d", ir, exp_ir, fetch_count);
            end
        end
        if (pc_count) begin
            pc_pulses++;
            check("pc_count_vs_pc_out_en", {31'h0, pc_out_en}, 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; halt_req = 1'b0; mem_ready = 1'b0;
        mem_data = 16'h0; exec_done = 1'b0;
        basic_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
        tick(); tick();
        reset = 1'b0;
        tick();
        check("reset_state", state_dbg, 0);
        check("reset_outs", w_outs, 0);
        check("reset_ir", ir, 0);
        check("reset_fetch_count", fetch_count, 0);

        // Basic fetch: zero-wait memory and executor.
        run = 1'b1; mem_ready = 1'b1; mem_data = 16'hA5C3; exec_done = 1'b1;
        exp_q.push_back(16'hA5C3);
        exp_pulses++;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("basic_state_%0d", i), state_dbg, basic_seq[i]);
            if (i == 4) check("basic_exec_start", exec_start, 1);
        end
        check("basic_ir", ir, 16'hA5C3);
        check("basic_fetch_count", fetch_count, 1);
        check("basic_pc_pulses", pc_pulses, exp_pulses);

        // Memory wait: ready low for three WAIT cycles (now in ADDR).
        en_cycles = pc_out_en & mem_rd;
        mem_ready = 1'b0; mem_data = 16'h1234; exec_done = 1'b0;
        exp_q.push_back(16'h1234);
        exp_pulses++;
        for (int i = 0; i < 4; i++) begin
            tick();
            en_cycles += int'(pc_out_en & mem_rd);
        end
        mem_ready = 1'b1;
        tick();
        check("memwait_load_state", state_dbg, 3);
        check("memwait_en_cycles", en_cycles, 5);
        check("memwait_pc_out_en_off", pc_out_en, 0);
        tick();
        check("memwait_incr_pc_count", pc_count, 1);
        tick();
        check("memwait_exec_start", exec_start, 1);
        check("memwait_fetch_count", fetch_count, 2);
        check("memwait_no_fault", fault, 0);

        // EXEC holds without exec_done even with halt_req; done+halt -> HALT.
        halt_req = 1'b1;
        tick();
        check("exec_hold_state", state_dbg, 5);
        check("exec_start_once", exec_start, 0);
        exec_done = 1'b1;
        tick();
        check("halt_state", state_dbg, 6);
        check("halt_halted", halted, 1);
        exec_done = 1'b0; halt_req = 1'b0;
        tick(); tick();
        check("halt_stays_with_run", state_dbg, 6);
        run = 1'b0;
        tick();
        check("halt_to_idle", state_dbg, 0);
        check("halt_cleared", halted, 0);

        // Dropping run during WAIT still completes the fetch.
        run = 1'b1; mem_ready = 1'b0; mem_data = 16'hBEEF;
        exp_q.push_back(16'hBEEF);
        exp_pulses++;
        tick(); tick();
        check("rundrop_in_wait", state_dbg, 2);
        run = 1'b0; mem_ready = 1'b1;
        tick(); tick(); tick();
        check("rundrop_exec", state_dbg, 5);
        exec_done = 1'b1;
        tick();
        check("rundrop_idle", state_dbg, 0);
        check("rundrop_fetch_count", fetch_count, 3);

        // Boundary: ready arrives on the 15th WAIT cycle.
        run = 1'b1; mem_ready = 1'b0; mem_data = 16'h0F0F;
        exp_q.push_back(16'h0F0F);
        exp_pulses++;
        tick();
        run = 1'b0;
        wait_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            wait_seen += int'(state_dbg == 3'd2);
        end
        check("boundary_wait_cycles", wait_seen, 15);
        mem_ready = 1'b1;
        tick();
        check("boundary_load", state_dbg, 3);
        check("boundary_no_fault", fault, 0);
        tick(); tick(); tick();
        check("boundary_idle", state_dbg, 0);
        check("boundary_fetch_count", fetch_count, 4);

        // Timeout: memory never ready.
        run = 1'b1; mem_ready = 1'b0; exec_done = 1'b0;
        tick();
        wait_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            wait_seen += int'(state_dbg == 3'd2);
        end
        check("timeout_wait_cycles", wait_seen, 15);
        tick();
        check("timeout_fault_state", state_dbg, 7);
        check("timeout_fault_outs", w_outs, 8'h01);
        tick(); tick(); tick();
        check("timeout_sticky", state_dbg, 7);
        check("timeout_no_pc_count", pc_pulses, exp_pulses);
        reset = 1'b1;
        tick();
        reset = 1'b0; run = 1'b0;
        check("post_fault_state", state_dbg, 0);
        check("post_fault_outs", w_outs, 0);
        check("post_fault_fetch_count", fetch_count, 0);
        check("post_fault_ir", ir, 0);

        // Reset during EXEC with exec_done low.
        run = 1'b1; mem_ready = 1'b1; mem_data = 16'h5A5A;
        exp_q.push_back(16'h5A5A);
        exp_pulses++;
        tick(); tick(); tick(); tick(); tick();
        check("midreset_in_exec", state_dbg, 5);
        reset = 1'b1;
        tick();
        check("midreset_state", state_dbg, 0);
        check("midreset_ir", ir, 0);
        check("midreset_fetch_count", fetch_count, 0);
        check("midreset_exec_start", exec_start, 0);
        reset = 1'b0;

        // 17 back-to-back fetches; the 4-bit counter instance must wrap to 1.
        exec_done = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            mem_data = 16'h1000 + 16'(i);
            exp_q.push_back(mem_data);
            exp_pulses++;
            for (int k = 0; k < 5; k++) tick();
        end
        check("wrap_cnt4", d4_fetch_count, 1);
        check("wrap_cnt16", fetch_count, 17);
        mem_data = 16'hC0DE;
        exp_q.push_back(16'hC0DE);
        exp_pulses++;
        run = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("final_idle", state_dbg, 0);
        check("final_cnt4", d4_fetch_count, 2);
        check("final_pc_pulses", pc_pulses, exp_pulses);
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
